// File: rtl/conv55_line_buffer.sv
// Line buffer feeding the 5x5 convolution stage: keeps the four previous rows
// in circular line memories and emits one vertical 5-pixel column per accepted pixel.
module conv55_line_buffer #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [BIT_WIDTH-1:0]   pix_in,
  output logic                   pix_ready,
  output logic [BIT_WIDTH*5-1:0] row1,
  output logic [BIT_WIDTH*5-1:0] row2,
  output logic [BIT_WIDTH*5-1:0] row3,
  output logic [BIT_WIDTH*5-1:0] row4,
  output logic [BIT_WIDTH*5-1:0] row5,
  output logic                   col_en,
  output logic                   conv_valid,
  output logic                   conv_last,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int OW = BIT_WIDTH * 5;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // FLUSH is the cycle after the last pixel: it lines frame_done up with the last conv_valid.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                window_pend;
  logic                last_pend;

  logic [BIT_WIDTH-1:0] mem0 [IMG_W];
  logic [BIT_WIDTH-1:0] mem1 [IMG_W];
  logic [BIT_WIDTH-1:0] mem2 [IMG_W];
  logic [BIT_WIDTH-1:0] mem3 [IMG_W];

  logic accept;
  logic col_last;
  logic fill_end;
  logic frame_end;

  function automatic logic [OW-1:0] sign_ext(input logic [BIT_WIDTH-1:0] p);
    return {{(OW-BIT_WIDTH){p[BIT_WIDTH-1]}}, p};
  endfunction

  assign accept    = pix_valid & pix_ready;
  assign col_last  = (col == CW'(IMG_W - 1));
  assign fill_end  = col_last && (row == RW'(3));
  assign frame_end = col_last && (row == RW'(IMG_H - 1));

  // Line memories shift one row down per column; the old contents are read before this edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem0[col] <= mem1[col];
      mem1[col] <= mem2[col];
      mem2[col] <= mem3[col];
      mem3[col] <= pix_in;
    end
  end

  // Frame sequencing, raster counters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      pix_ready   <= 1'b0;
      busy        <= 1'b0;
      row1        <= '0;
      row2        <= '0;
      row3        <= '0;
      row4        <= '0;
      row5        <= '0;
      col_en      <= 1'b0;
      conv_valid  <= 1'b0;
      conv_last   <= 1'b0;
      frame_done  <= 1'b0;
      window_pend <= 1'b0;
      last_pend   <= 1'b0;
    end else begin
      col_en     <= 1'b0;
      frame_done <= 1'b0;
      // The conv stage latches on col_en; its window is valid the cycle after.
      conv_valid <= col_en & window_pend;
      conv_last  <= col_en & window_pend & last_pend;

      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
          end else begin
            pix_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        FILL: begin
          if (accept && fill_end) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            row1        <= sign_ext(mem0[col]);
            row2        <= sign_ext(mem1[col]);
            row3        <= sign_ext(mem2[col]);
            row4        <= sign_ext(mem3[col]);
            row5        <= sign_ext(pix_in);
            col_en      <= 1'b1;
            window_pend <= (col >= CW'(4));
            last_pend   <= frame_end;
            if (frame_end) begin
              state     <= FLUSH;
              pix_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          frame_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv55_line_buffer.sv
// Self-checking bench for conv55_line_buffer on an 8x8 frame: a control vector
// table, randomized frames against an image-level reference, and a 5x5 sum check.
module tb_conv55_line_buffer;

  localparam int BW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int OW = BW * 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [BW-1:0] pix_in = '0;
  logic          pix_ready;
  logic [OW-1:0] row1, row2, row3, row4, row5;
  logic          col_en, conv_valid, conv_last, frame_done, busy;

  conv55_line_buffer #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .row1(row1), .row2(row2), .row3(row3), .row4(row4),
    .row5(row5), .col_en(col_en), .conv_valid(conv_valid), .conv_last(conv_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] sx(input logic [BW-1:0] p);
    return {{(OW-BW){p[BW-1]}}, p};
  endfunction

  // Source image of the frame being fed
  logic signed [BW-1:0] img [H][W];

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? BW'(r * 8 + c) : (mode == 1) ? -8'sd1 : BW'($urandom_range(255));
  endtask

  function automatic longint ref_sum(input int r, input int c);
    longint s = 0;
    for (int i = r - 4; i <= r; i++)
      for (int j = c - 4; j <= c; j++)
        s += longint'(img[i][j]);
    return s;
  endfunction

  // Reference model: frame progress as pixel count, expectations from the image itself
  localparam int P_IDLE = 0, P_ACT = 1, P_FLUSH = 2, P_DONE = 3;
  int            phase = P_IDLE;
  int            n_acc = 0;
  logic [OW-1:0] e_rows [5] = '{default: '0};
  bit            e_ready, e_busy, e_col_en, e_cv, e_cl, e_fd, e_win, e_lastw;
  longint        e_sum, pend_sum;

  always @(posedge clk or negedge rst) begin
    int r, c;
    if (!rst) begin
      phase = P_IDLE; n_acc = 0;
      e_ready = 0; e_busy = 0; e_col_en = 0; e_cv = 0; e_cl = 0; e_fd = 0;
      e_win = 0; e_lastw = 0;
      for (int k = 0; k < 5; k++) e_rows[k] = '0;
    end else begin
      e_cv = e_col_en && e_win;
      e_cl = e_cv && e_lastw;
      if (e_cv) e_sum = pend_sum;
      e_col_en = 0;
      case (phase)
        P_IDLE:  if (start) begin phase = P_ACT; n_acc = 0; end
        P_ACT: begin
          if (pix_valid) begin
            r = n_acc / W; c = n_acc % W;
            if (r >= 4) begin
              e_col_en = 1;
              for (int k = 0; k < 5; k++) e_rows[k] = sx(img[r-4+k][c]);
              e_win = (c >= 4);
              e_lastw = (n_acc == W * H - 1);
              if (c >= 4) pend_sum = ref_sum(r, c);
            end
            n_acc++;
            if (n_acc == W * H) phase = P_FLUSH;
          end
        end
        P_FLUSH: phase = P_DONE;
        default: phase = P_IDLE;
      endcase
      e_fd = (phase == P_DONE);
      e_busy = (phase != P_IDLE);
      e_ready = (phase == P_ACT);
    end
  end

  // Stand-in for the conv stage: 5 latched columns, shifted on col_en
  logic [OW-1:0] cw [5][5] = '{default: '0};
  logic [OW-1:0] rows_a [5];
  assign rows_a[0] = row1;
  assign rows_a[1] = row2;
  assign rows_a[2] = row3;
  assign rows_a[3] = row4;
  assign rows_a[4] = row5;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 5; j++) for (int k = 0; k < 5; k++) cw[j][k] = '0;
    end else if (col_en) begin
      for (int j = 0; j < 4; j++) for (int k = 0; k < 5; k++) cw[j][k] = cw[j+1][k];
      for (int k = 0; k < 5; k++) cw[4][k] = rows_a[k];
    end
  end

  function automatic longint conv_sum();
    longint s = 0;
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 5; k++)
        s += longint'($signed(cw[j][k]));
    return s;
  endfunction

  int     cen_cnt = 0;
  int     cv_cnt = 0;
  longint first_sum = 0;

  // Cycle checker, sampled on the falling edge
  always @(negedge clk) begin
    chk("pix_ready", 64'(pix_ready), 64'(e_ready));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("col_en", 64'(col_en), 64'(e_col_en));
    chk("conv_valid", 64'(conv_valid), 64'(e_cv));
    chk("conv_last", 64'(conv_last), 64'(e_cl));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    for (int k = 0; k < 5; k++) chk($sformatf("row%0d", k + 1), 64'(rows_a[k]), 64'(e_rows[k]));
    if (e_cv) chk("conv_sum", 64'(conv_sum()), 64'(e_sum));
    if (col_en) cen_cnt++;
    if (conv_valid) begin
      if (cv_cnt == 0) first_sum = conv_sum();
      cv_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Feeds one frame; returns in the DONE cycle, or right after stop_at pixels
  task automatic run_frame(input int gap, input int start_hold, input int stop_at, input bit mid_start);
    int k = 0;
    int guard = 0;
    bit acc;
    start = 1'b1;
    @(posedge clk); #2;
    cen_cnt = 0; cv_cnt = 0;
    repeat (start_hold - 1) begin @(posedge clk); #2; end
    start = 1'b0;
    while (k < W * H && k != stop_at && guard < 4000) begin
      pix_valid = ($urandom_range(99) >= 32'(gap));
      pix_in = img[k / W][k % W];
      start = mid_start && (k == 40);
      acc = pix_valid && pix_ready;
      @(posedge clk); #2;
      guard++;
      if (acc) k++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    chk("frame_timeout", 64'(guard >= 4000), 64'(0));
    if (k == W * H) begin @(posedge clk); #2; end
  endtask

  typedef struct {
    bit rst, start, pv;
    bit ready, busy;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{rst: 0, start: 1, pv: 1, ready: 0, busy: 0};
    tbl[1] = '{rst: 0, start: 1, pv: 0, ready: 0, busy: 0};
    tbl[2] = '{rst: 1, start: 0, pv: 1, ready: 0, busy: 0};
    tbl[3] = '{rst: 1, start: 0, pv: 0, ready: 0, busy: 0};
    tbl[4] = '{rst: 1, start: 1, pv: 0, ready: 1, busy: 1};
    tbl[5] = '{rst: 1, start: 1, pv: 1, ready: 1, busy: 1};
    tbl[6] = '{rst: 1, start: 0, pv: 0, ready: 1, busy: 1};
    tbl[7] = '{rst: 0, start: 0, pv: 1, ready: 0, busy: 0};
    tbl[8] = '{rst: 1, start: 0, pv: 1, ready: 0, busy: 0};
    fill_img(0);

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; pix_valid = tbl[i].pv; pix_in = '0;
      @(posedge clk); #3;
      chk("tbl_ready", 64'(pix_ready), 64'(tbl[i].ready));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].busy));
    end
    pix_valid = 1'b0;

    // Random activity while reset is held, then a quiet idle stretch
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom_range(1)); pix_valid = 1'($urandom_range(1));
      @(posedge clk); #2;
      chk("rst_busy", 64'(busy), 64'(0));
    end
    start = 1'b0; pix_valid = 1'b0; rst = 1'b1;
    idle(3);
    chk("idle_busy", 64'(busy), 64'(0));

    // Continuous ramp frame
    run_frame(0, 1, -1, 1'b0);
    idle(2);
    chk("cen_count", 64'(cen_cnt), 64'(32));
    chk("cv_count", 64'(cv_cnt), 64'(16));
    chk("first_sum", 64'(first_sum), 64'(450));

    // Same frame with ~50% bubbles
    run_frame(50, 1, -1, 1'b0);
    idle(2);
    chk("gap_cen_count", 64'(cen_cnt), 64'(32));
    chk("gap_cv_count", 64'(cv_cnt), 64'(16));

    // Start during RUN ignored; back-to-back start across the frame_done cycle
    run_frame(20, 1, -1, 1'b1);
    run_frame(0, 2, -1, 1'b0);
    idle(2);
    chk("b2b_cv_count", 64'(cv_cnt), 64'(16));
    chk("b2b_first_sum", 64'(first_sum), 64'(450));

    // Reset after pixel (5,3), then an all -1 frame
    run_frame(0, 1, 44, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_col_en", 64'(col_en), 64'(0));
    chk("mid_rst_row5", 64'(row5), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #2;
    rst = 1'b1;
    fill_img(1);
    idle(2);
    run_frame(30, 1, -1, 1'b0);
    idle(2);
    chk("neg_row1", 64'(row1), 64'({OW{1'b1}}));
    chk("neg_row5", 64'(row5), 64'({OW{1'b1}}));
    chk("neg_cv_count", 64'(cv_cnt), 64'(16));

    // Random pixels with bubbles
    fill_img(2);
    run_frame(40, 1, -1, 1'b0);
    idle(2);
    chk("rnd_cen_count", 64'(cen_cnt), 64'(32));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
